// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one memory port between CPU and loader
module mem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    output logic              cpu_ack_o,
    output logic              cpu_rvalid_o,
    output logic [DATA_W-1:0] cpu_rdata_o,
    input  logic              dbg_req_i,
    input  logic              dbg_we_i,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    input  logic [DATA_W-1:0] dbg_wdata_i,
    output logic              dbg_ack_o,
    output logic              dbg_rvalid_o,
    output logic [DATA_W-1:0] dbg_rdata_o,
    input  logic              dbg_lock_i,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    typedef enum logic [1:0] {IDLE, ISSUE_CPU, ISSUE_DBG} state_t;

    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;  // 1 = loader granted last
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic              dbg_ack_q, dbg_ack_d;
    logic              cpu_rvalid_q, cpu_rvalid_d;
    logic              dbg_rvalid_q, dbg_rvalid_d;
    logic              grant_cpu, grant_dbg;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            cpu_ack_q    <= 1'b0;
            dbg_ack_q    <= 1'b0;
            cpu_rvalid_q <= 1'b0;
            dbg_rvalid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            cpu_ack_q    <= cpu_ack_d;
            dbg_ack_q    <= dbg_ack_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            dbg_rvalid_q <= dbg_rvalid_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        mem_en_d     = 1'b0;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        cpu_ack_d    = 1'b0;
        dbg_ack_d    = 1'b0;
        grant_cpu    = 1'b0;
        grant_dbg    = 1'b0;
        // mem_we_q still holds the issuing access's direction during ISSUE_x
        cpu_rvalid_d = (state_q == ISSUE_CPU) && !mem_we_q;
        dbg_rvalid_d = (state_q == ISSUE_DBG) && !mem_we_q;

        case (state_q)
            IDLE: begin
                if (dbg_lock_i) begin
                    grant_dbg = dbg_req_i;
                end else if (cpu_req_i && dbg_req_i) begin
                    grant_cpu = last_grant_q;
                    grant_dbg = !last_grant_q;
                end else begin
                    grant_cpu = cpu_req_i;
                    grant_dbg = dbg_req_i;
                end

                if (grant_cpu) begin
                    state_d      = ISSUE_CPU;
                    last_grant_d = 1'b0;
                    mem_en_d     = 1'b1;
                    mem_we_d     = cpu_we_i;
                    mem_addr_d   = cpu_addr_i;
                    mem_wdata_d  = cpu_wdata_i;
                    cpu_ack_d    = 1'b1;
                end else if (grant_dbg) begin
                    state_d      = ISSUE_DBG;
                    last_grant_d = 1'b1;
                    mem_en_d     = 1'b1;
                    mem_we_d     = dbg_we_i;
                    mem_addr_d   = dbg_addr_i;
                    mem_wdata_d  = dbg_wdata_i;
                    dbg_ack_d    = 1'b1;
                end
            end
            ISSUE_CPU, ISSUE_DBG: state_d = IDLE;
            default:              state_d = IDLE;
        endcase
    end

    assign mem_en_o     = mem_en_q;
    assign mem_we_o     = mem_we_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_wdata_o  = mem_wdata_q;
    assign cpu_ack_o    = cpu_ack_q;
    assign dbg_ack_o    = dbg_ack_q;
    assign cpu_rvalid_o = cpu_rvalid_q;
    assign dbg_rvalid_o = dbg_rvalid_q;
    assign cpu_rdata_o  = mem_rdata_i;
    assign dbg_rdata_o  = mem_rdata_i;

endmodule
